// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run sequencer for the 3-bit next-state core.
// On start it clears the core and steps it for N clocks (N clamped to
// MAX_STEPS). It records core_y at each step and pulses done at the end.
// The captured results are held until the next accepted start.
// Optional feature macro: CORE_RUN_ABORT_EN adds the abort input and the
// aborted output, which cancel a run while it is in progress.
module core_run_ctrl #(
  parameter int MAX_STEPS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_steps,
  output logic                 busy,
  output logic                 done,
  output logic                 core_rst,
  output logic                 core_en,
  input  logic                 core_y,
  output logic [MAX_STEPS-1:0] y_log,
  output logic [CNT_W-1:0]     ones_cnt
`ifdef CORE_RUN_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]     step_q, step_d;
  logic [CNT_W-1:0]     ones_q, ones_d;
  logic [MAX_STEPS-1:0] ylog_q, ylog_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 en_q, en_d;
  logic                 abort_req;

`ifdef CORE_RUN_ABORT_EN
  logic                 aborted_q, aborted_d;
  assign abort_req = abort;
  assign aborted   = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // Next-state, capture and registered-output computation
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    step_d  = step_q;
    ones_d  = ones_q;
    ylog_d  = ylog_q;
`ifdef CORE_RUN_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = (num_steps > MAX_CNT) ? MAX_CNT : num_steps;
          step_d  = '0;
          ones_d  = '0;
          ylog_d  = '0;
          state_d = S_CLEAR;
`ifdef CORE_RUN_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      S_CLEAR: begin
        step_d = '0;
        if (abort_req) begin
          state_d = S_IDLE;
`ifdef CORE_RUN_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (n_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The step is captured even on an aborting edge, so partial
        // results include it.
        ylog_d = ylog_q | ({{(MAX_STEPS-1){1'b0}}, core_y} << step_q);
        ones_d = ones_q + {{(CNT_W-1){1'b0}}, core_y};
        if (abort_req) begin
          state_d = S_IDLE;
`ifdef CORE_RUN_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (step_q == n_q - CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CLEAR) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    en_d   = (state_d == S_RUN);
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      step_q  <= '0;
      ones_q  <= '0;
      ylog_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
`ifdef CORE_RUN_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      step_q  <= step_d;
      ones_q  <= ones_d;
      ylog_q  <= ylog_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
`ifdef CORE_RUN_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // The core is held in reset with the controller and during CLEAR
  assign core_rst = reset || (state_q == S_CLEAR);
  assign busy     = busy_q;
  assign done     = done_q;
  assign core_en  = en_q;
  assign y_log    = ylog_q;
  assign ones_cnt = ones_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed bench for core_run_ctrl with a small model of
// the core whose y sequence after clear is 0,1,1,0 repeating.
module tb_core_run_ctrl;

  localparam int MAX_STEPS = 16;
  localparam int CNT_W     = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [CNT_W-1:0]     num_steps;
  logic                 busy;
  logic                 done;
  logic                 core_rst;
  logic                 core_en;
  logic                 core_y;
  logic [MAX_STEPS-1:0] y_log;
  logic [CNT_W-1:0]     ones_cnt;
`ifdef CORE_RUN_ABORT_EN
  logic                 abort;
  logic                 aborted;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  core_run_ctrl #(.MAX_STEPS(MAX_STEPS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_steps (num_steps),
    .busy      (busy),
    .done      (done),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .core_y    (core_y),
    .y_log     (y_log),
    .ones_cnt  (ones_cnt)
`ifdef CORE_RUN_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  always #5 clk = ~clk;

  // Core model: 3-bit state, cleared by core_rst, advances when enabled
  logic [2:0] cst = 3'd0;
  always @(posedge clk) begin
    if (core_rst) cst <= 3'd0;
    else if (core_en) cst <= cst + 3'd1;
  end
  assign core_y = (cst[1:0] == 2'd1) || (cst[1:0] == 2'd2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  // Launch a run and follow it until done; optionally re-pulse start at
  // cycle 'repulse' (counted from the accepting edge).
  task automatic run(input int n, input int repulse, output int dcyc,
                     output int bcnt, output int ecnt);
    dcyc = -1;
    bcnt = 0;
    ecnt = 0;
    num_steps = n[CNT_W-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy) bcnt++;
      if (core_en) ecnt++;
      if (done) begin
        dcyc = cyc;
        break;
      end
      start = (cyc == repulse);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, bc, ec, cnt, d1, d2;
    reset = 1'b1;
    start = 1'b0;
    num_steps = '0;
`ifdef CORE_RUN_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_en", 32'(core_en), 32'd0);
    chk("rst_ylog", 32'(y_log), 32'd0);
    chk("rst_ones", 32'(ones_cnt), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_core_rst", 32'(core_rst), 32'd0);

    // 8-step run
    run(8, 0, dc, bc, ec);
    chk("r8_done_cyc", 32'(dc), 32'd10);
    chk("r8_busy", 32'(bc), 32'd9);
    chk("r8_en", 32'(ec), 32'd8);
    chk("r8_ylog", 32'(y_log), 32'h0066);
    chk("r8_ones", 32'(ones_cnt), 32'd4);
    @(negedge clk);
    chk("r8_done_1cyc", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("r8_hold_ylog", 32'(y_log), 32'h0066);
    chk("r8_hold_ones", 32'(ones_cnt), 32'd4);

    // zero-step run clears previous results
    run(0, 0, dc, bc, ec);
    chk("r0_done_cyc", 32'(dc), 32'd2);
    chk("r0_en", 32'(ec), 32'd0);
    chk("r0_ylog", 32'(y_log), 32'd0);
    chk("r0_ones", 32'(ones_cnt), 32'd0);
    @(negedge clk);

    // clamped run
    run(20, 0, dc, bc, ec);
    chk("r20_done_cyc", 32'(dc), 32'd18);
    chk("r20_en", 32'(ec), 32'd16);
    chk("r20_ylog", 32'(y_log), 32'h6666);
    chk("r20_ones", 32'(ones_cnt), 32'd8);
    @(negedge clk);

    // reset at RUN step 2 of a 5-step run
    num_steps = 5'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_core_rst", 32'(core_rst), 32'd1);
    @(negedge clk);
    chk("run_core_rst", 32'(core_rst), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_ylog", 32'(y_log), 32'h0002);
    chk("mid_ones", 32'(ones_cnt), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_en", 32'(core_en), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_ylog", 32'(y_log), 32'd0);
    chk("mr_ones", 32'(ones_cnt), 32'd0);
    chk("mr_core_rst", 32'(core_rst), 32'd1);
    reset = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("mr_no_done", 32'(cnt), 32'd0);
    run(3, 0, dc, bc, ec);
    chk("r3_done_cyc", 32'(dc), 32'd5);
    chk("r3_ylog", 32'(y_log), 32'h0006);
    chk("r3_ones", 32'(ones_cnt), 32'd2);
    @(negedge clk);

    // start held high: back-to-back 2-step runs
    num_steps = 5'd2;
    start = 1'b1;
    d1 = -1;
    d2 = -1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) begin
          d2 = c;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first", 32'(d1), 32'd3);
    chk("b2b_gap", 32'(d2 - d1), 32'd5);
    chk("b2b_count", 32'(cnt), 32'd2);

    // start pulse during busy is ignored
    run(3, 2, dc, bc, ec);
    chk("ign_done_cyc", 32'(dc), 32'd5);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("ign_no_rerun", 32'(cnt), 32'd0);

`ifdef CORE_RUN_ABORT_EN
    // abort at RUN step 3 of an 8-step run
    num_steps = 5'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_aborted", 32'(aborted), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_en", 32'(core_en), 32'd0);
    chk("ab_ylog", 32'(y_log), 32'h0006);
    chk("ab_ones", 32'(ones_cnt), 32'd2);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("ab_no_done", 32'(cnt), 32'd0);
    chk("ab_hold", 32'(aborted), 32'd1);
    run(2, 0, dc, bc, ec);
    chk("ab_clear", 32'(aborted), 32'd0);
    chk("ab_next_ylog", 32'(y_log), 32'h0002);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
